// File: rtl/mmu_tlb.sv
// Data-side address translation: MIPS segment decode, fully-associative 4 KB TLB,
// uncached-window detection, and a one-deep registered response with valid/ready.
module mmu_tlb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned IDX_W       = 3,
  parameter logic [15:0] PERIPH_HI   = 16'h1faf
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [31:0]      req_vaddr,
  output logic             req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_paddr,
  output logic             resp_no_cache,
  output logic             resp_miss,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [19:0]      wr_vpn,
  input  logic [19:0]      wr_pfn,
  input  logic             wr_c,
  input  logic             wr_v,
  input  logic             flush
);

  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] pfn;
    logic        c;
    logic        v;
  } tlb_entry_t;

  tlb_entry_t entries [NUM_ENTRIES];

  logic        hit;
  logic [19:0] hit_pfn;
  logic        hit_c;
  logic [31:0] lk_paddr;
  logic        lk_no_cache;
  logic        lk_miss;
  logic        accept;

  assign req_ready = ~resp_valid | resp_ready;
  assign accept    = req_valid & req_ready;

  // Associative match; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_c   = 1'b0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (entries[IDX_W'(i)].v && (entries[IDX_W'(i)].vpn == req_vaddr[31:12])) begin
        hit     = 1'b1;
        hit_pfn = entries[IDX_W'(i)].pfn;
        hit_c   = entries[IDX_W'(i)].c;
      end
    end
  end

  // Segment decode plus peripheral-window override on the final physical address.
  always_comb begin
    lk_paddr    = '0;
    lk_no_cache = 1'b0;
    lk_miss     = 1'b0;
    if (req_vaddr[31:29] == SEG_KSEG0) begin
      lk_paddr = {3'b000, req_vaddr[28:0]};
    end else if (req_vaddr[31:29] == SEG_KSEG1) begin
      lk_paddr    = {3'b000, req_vaddr[28:0]};
      lk_no_cache = 1'b1;
    end else if (hit) begin
      lk_paddr    = {hit_pfn, req_vaddr[11:0]};
      lk_no_cache = ~hit_c;
    end else begin
      lk_miss = 1'b1;
    end
    if (!lk_miss && (lk_paddr[31:16] == PERIPH_HI)) begin
      lk_no_cache = 1'b1;
    end
  end

  // Entry storage: flush clears valids, a same-edge write then overrides its slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        entries[IDX_W'(i)] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (flush) begin
          entries[IDX_W'(i)].v <= 1'b0;
        end
        if (wr_en && (wr_index == IDX_W'(i))) begin
          entries[IDX_W'(i)] <= '{vpn: wr_vpn, pfn: wr_pfn, c: wr_c, v: wr_v};
        end
      end
    end
  end

  // One-deep response register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_no_cache <= 1'b0;
      resp_miss     <= 1'b0;
    end else if (accept) begin
      resp_valid    <= 1'b1;
      resp_paddr    <= lk_paddr;
      resp_no_cache <= lk_no_cache;
      resp_miss     <= lk_miss;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Parametrised address-translation unit for the data-side memory path; sits between the load/store stage and the cache/uncached bridge.
- Decodes MIPS segments: kseg0/kseg1 are unmapped; kuseg/kseg2/kseg3 go through an N-entry fully-associative TLB with 4 KB pages.
- Generates the uncached flag from kseg1 and from a configurable peripheral window.
- Registered lookup with a valid/ready response handshake, plus a software write port and a flush.

Parameters:
- NUM_ENTRIES, 8, number of TLB entries, power of two, range 2..32.
- IDX_W, 3, index width; must equal log2(NUM_ENTRIES).
- PERIPH_HI, 16'h1faf, physical address bits [31:16] of the 64 KB uncached peripheral window.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request valid.
- req_vaddr  in  32  virtual address.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- resp_valid  out  1  registered response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_paddr  out  32  physical address.
- resp_no_cache  out  1  access must bypass the cache.
- resp_miss  out  1  TLB refill exception (no valid matching entry).
- wr_en  in  1  write one TLB entry.
- wr_index  in  IDX_W  entry to write.
- wr_vpn  in  20  virtual page number, vaddr[31:12].
- wr_pfn  in  20  physical frame number.
- wr_c  in  1  entry cacheable.
- wr_v  in  1  entry valid.
- flush  in  1  invalidate all entries.

Behaviour:
- Reset (async, resetn=0):
  - All entry valid bits clear.
  - resp_valid=0; resp_paddr=0, resp_no_cache=0, resp_miss=0.
  - Releasing reset mid-transaction discards any pending response.
- req_ready = ~resp_valid | resp_ready, i.e. a one-deep output register.
- Latency: a request accepted at edge N has its response valid after edge N, visible in cycle N+1.
  - Back-to-back accepts give one response per cycle.
  - A response is held stable while resp_valid && ~resp_ready.
- Segment decode on vaddr[31:29]:
  - 3'b100 (kseg0): paddr={3'b0,vaddr[28:0]}, no_cache=0, miss=0.
  - 3'b101 (kseg1): paddr={3'b0,vaddr[28:0]}, no_cache=1, miss=0.
  - Anything else: mapped.
- Mapped lookup:
  - Compare vaddr[31:12] against every valid entry's vpn.
  - Hit: paddr={pfn,vaddr[11:0]}, no_cache=~c, miss=0.
  - No hit: miss=1, paddr=0, no_cache=0.
  - Entries with v=0 never match.
  - Multiple hits are a software error; the lowest index wins, deterministically.
- Peripheral window: if the final paddr[31:16]==PERIPH_HI and miss=0, then no_cache=1 regardless of segment or entry c.
- Lookup is computed combinationally from the entry state before the clock edge and registered at accept.
  - A wr_en or flush in the same cycle as an accepted request does not affect that request's result.
  - It does affect the next request.
- Write: on the edge with wr_en=1, entry[wr_index] takes {vpn,pfn,c,v}.
- Flush: on the edge with flush=1, all valid bits clear.
- flush and wr_en in the same cycle: flush applies first, then the write, so entry[wr_index] ends up with wr_v.
- Writes and flush are accepted every cycle, independent of the handshake.

Test Plan:
- Reset then req vaddr=32'h8000_1234 -> next cycle resp_valid=1, paddr=32'h0000_1234, no_cache=0, miss=0.
- req vaddr=32'hbfaf_0010 -> paddr=32'h1faf_0010, no_cache=1.
- Write idx2 {vpn=20'h00400, pfn=20'h1faf0, c=1, v=1}, then req 32'h0040_0abc -> paddr=32'h1faf_0abc, no_cache=1 (peripheral window).
- Write idx5 {vpn=20'h12345, pfn=20'h00777, c=1, v=1}; req 32'h1234_5ff8 -> paddr=32'h0077_7ff8, no_cache=0. Then flush and repeat -> miss=1, paddr=0.
- Same-cycle write idx0 vpn=20'h00001 with req 32'h0000_1000 -> miss=1; the following req with the same address -> hit.
- Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and the response is held stable. Raise resp_ready -> the queued request completes next cycle. Assert resetn=0 mid-stall -> resp_valid drops immediately.
